// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   XLEN      : operand/result width of the core
//   CNT_W     : width of the iteration counter
//   op_e      : operation encodings driven by the EX stage
//   state_e   : control FSM states
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Divide-class ops share the restoring datapath.
    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between EX and the multiply/divide unit.
//   start, op, a, b, flush : request side (master drives)
//   busy, done, result     : response side (slave drives)
import muldiv_pkg::*;

interface muldiv_if #(
    parameter int unsigned WIDTH = XLEN
);
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
//   div     : 1 = divide step, 0 = multiply step
//   hi, lo  : accumulator halves (hi/lo for multiply, r/q for divide)
//   b       : multiplier / divisor
//   hi_next, lo_next : accumulator after this iteration
import muldiv_pkg::*;

module muldiv_step #(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        // Multiply: conditional add with carry out, then {c, hi, lo} >> 1.
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : (WIDTH+1)'(0));
        // Divide: {r, q} << 1 keeps r's old MSB so the trial subtract is exact.
        rem_sh = {hi, lo[WIDTH-1]};
        trial  = rem_sh - {1'b0, b};

        if (div) begin
            if (!trial[WIDTH]) begin
                hi_next = trial[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = rem_sh[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit for the EX stage.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of muldiv_if (start/op/a/b/flush in,
//              busy/done/result out)
// One op per accepted start; WIDTH iterations, then a one-cycle done.
import muldiv_pkg::*;

module muldiv_unit #(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_step, lo_step;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div     (op_is_div(op_q)),
        .hi      (hi_q),
        .lo      (lo_q),
        .b       (b_q),
        .hi_next (hi_step),
        .lo_next (lo_step)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand, accumulator, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_MUL;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d  = bus.op;
                    b_d   = bus.b;
                    hi_d  = '0;
                    lo_d  = bus.a;
                    cnt_d = CW'(WIDTH - 1);
                    // Divide by zero bypasses the iterations entirely.
                    if (op_is_div(bus.op) && (bus.b == '0)) begin
                        state_d  = DONE;
                        result_d = (bus.op == OP_DIVU) ? '1 : bus.a;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = hi_step;
                    lo_d  = lo_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        // op[0] picks the high half (MULHU) or remainder (REMU).
                        result_d = op_q[0] ? hi_step : lo_step;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // done is gated by flush in the same cycle so an aborted op never reports.
    assign bus.done   = (state_q == DONE) && !bus.flush;
    assign bus.busy   = busy_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus random ops checked
// against an arithmetic reference model.
import muldiv_pkg::*;

module tb_muldiv_unit;

    localparam int unsigned W = XLEN;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [W-1:0] last_res = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_if #(.WIDTH(W)) bus();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the arithmetic definition of each op.
    function automatic logic [W-1:0] model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        prod = (2*W)'(a) * (2*W)'(b);
        case (op)
            OP_MUL:   return prod[W-1:0];
            OP_MULHU: return prod[2*W-1:W];
            OP_DIVU:  return (b == 0) ? {W{1'b1}} : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drives a one-cycle start from a negedge; optionally records the expected response.
    task automatic issue(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        bit   div0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (push) begin
            div0  = ((op == OP_DIVU) || (op == OP_REMU)) && (b == 0);
            e.res = model(op, a, b);
            e.cyc = cyc + 1 + (div0 ? 0 : W);
            exp_q.push_back(e);
            last_res = e.res;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts busy cycles until the unit is idle again (bounded).
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("idle_timeout", 32'(n >= 200), 32'(0));
    endtask

    // Monitor: every done must match the head of the scoreboard in value and cycle.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done result=%0h cyc=%0d", bus.result, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", bus.result, e.res);
                check("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        op_e op;
        logic [W-1:0] ra, rb;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = OP_MUL;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",   32'(bus.busy), 32'(0));
        check("rst_done",   32'(bus.done), 32'(0));
        check("rst_result", bus.result,    32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic multiply with busy-window length.
        issue(OP_MUL, 32'd7, 32'd6, 1'b1);
        wait_idle(n);
        check("mul_busy_cycles", 32'(n), 32'(W + 1));

        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_idle(n);
        issue(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_idle(n);
        issue(OP_DIVU,  32'd100, 32'd7, 1'b1); wait_idle(n);
        issue(OP_REMU,  32'd100, 32'd7, 1'b1); wait_idle(n);
        issue(OP_DIVU,  32'd5,   32'd9, 1'b1); wait_idle(n);
        issue(OP_REMU,  32'd5,   32'd9, 1'b1); wait_idle(n);

        // Divide by zero completes in one cycle.
        issue(OP_DIVU, 32'hDEAD_BEEF, 32'd0, 1'b1); wait_idle(n);
        check("divu0_busy_cycles", 32'(n), 32'(1));
        issue(OP_REMU, 32'h0000_1234, 32'd0, 1'b1); wait_idle(n);
        check("remu0_busy_cycles", 32'(n), 32'(1));

        // Flush at the 10th RUN cycle: no done, idle next cycle, result held.
        issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        check("flush_done", 32'(bus.done), 32'(0));
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy",   32'(bus.busy), 32'(0));
        check("flush_result", bus.result,    last_res);
        issue(OP_DIVU, 32'd9, 32'd3, 1'b1); wait_idle(n);
        check("post_flush_busy_cycles", 32'(n), 32'(W + 1));

        // Start re-pulsed mid-run is ignored.
        issue(OP_MUL, 32'd7, 32'd6, 1'b1);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd123; bus.b = 32'd456;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(n);

        // Reset mid-run clears outputs at once.
        issue(OP_DIVU, 32'hFFFF_0000, 32'd77, 1'b0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy",   32'(bus.busy), 32'(0));
        check("midrst_done",   32'(bus.done), 32'(0));
        check("midrst_result", bus.result,    32'h0);
        last_res = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(OP_REMU, 32'd1000, 32'd33, 1'b1); wait_idle(n);

        // start with flush in IDLE is rejected.
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MUL; bus.a = 32'd3; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start_busy", 32'(bus.busy), 32'(0));
        repeat (3) @(negedge clk);

        // Random ops, back to back, including zero and small divisors.
        for (int i = 0; i < 40; i++) begin
            op = op_e'(2'($urandom_range(0, 3)));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            issue(op, ra, rb, 1'b1);
            wait_idle(n);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
